// File: rtl/calc_avalon_engine.sv
// Avalon-MM register slave for the hardware calculator, with an iterative
// multiply/divide engine, keypad-side write port, sticky status flags and an interrupt.
module calc_avalon_engine #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  input  logic              loc_we,
  input  logic [1:0]        loc_sel,
  input  logic [DATA_W-1:0] loc_wdata,
  input  logic              loc_start,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [2:0]        op_code,
  output logic [DATA_W-1:0] result,
  output logic              busy,
  output logic              done,
  output logic              irq
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ITER, S_FIN} state_t;
  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR, OP_XOR, OP_PASS
  } op_t;

  state_t             state_q, state_d;
  op_t                snap_op_q, snap_op_d;
  logic [DATA_W-1:0]  op_a_q, op_a_d, op_b_q, op_b_d;
  logic [2:0]         op_code_q, op_code_d;
  logic               irq_en_q, irq_en_d;
  logic [DATA_W-1:0]  snap_a_q, snap_a_d, snap_b_q, snap_b_d;
  logic [DATA_W-1:0]  acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  res_lo_q, res_lo_d, res_hi_q, res_hi_d;
  logic               busy_q, busy_d, done_q, done_d, dbz_q, dbz_d, ovf_q, ovf_d;
  logic [DATA_W-1:0]  rd_q, rd_d;

  logic               ctrl_wr, start_req, clear_req;
  logic [DATA_W:0]    add_s, sub_s, mul_sum, div_sh;
  logic [DATA_W-1:0]  div_diff;
  logic               div_ge;

  always_comb begin
    state_d   = state_q;
    snap_op_d = snap_op_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    op_code_d = op_code_q;
    irq_en_d  = irq_en_q;
    snap_a_d  = snap_a_q;
    snap_b_d  = snap_b_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    cnt_d     = cnt_q;
    res_lo_d  = res_lo_q;
    res_hi_d  = res_hi_q;
    busy_d    = busy_q;
    done_d    = done_q;
    dbz_d     = dbz_q;
    ovf_d     = ovf_q;
    rd_d      = rd_q;

    add_s    = {1'b0, snap_a_q} + {1'b0, snap_b_q};
    sub_s    = {1'b0, snap_a_q} - {1'b0, snap_b_q};
    mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, snap_a_q} : '0);
    div_sh   = {acc_hi_q, acc_lo_q[DATA_W-1]};
    div_ge   = (div_sh >= {1'b0, snap_b_q});
    div_diff = div_sh[DATA_W-1:0] - snap_b_q;

    // Local port applied first so a same-register Avalon write overrides it.
    if (loc_we) begin
      case (loc_sel)
        2'd0:    op_a_d    = loc_wdata;
        2'd1:    op_b_d    = loc_wdata;
        2'd2:    op_code_d = loc_wdata[2:0];
        default: ;
      endcase
    end
    if (write) begin
      case (address)
        ADDR_W'(0): op_a_d    = write_data;
        ADDR_W'(1): op_b_d    = write_data;
        ADDR_W'(2): op_code_d = write_data[2:0];
        ADDR_W'(7): irq_en_d  = write_data[0];
        default: ;
      endcase
    end

    ctrl_wr   = write && (address == ADDR_W'(3));
    start_req = (ctrl_wr && write_data[0]) || loc_start;
    clear_req = ctrl_wr && write_data[1];
    if (clear_req) begin
      done_d = 1'b0;
      dbz_d  = 1'b0;
      ovf_d  = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start_req) begin
          state_d = S_LOAD;
          done_d  = 1'b0;
          dbz_d   = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      S_LOAD: begin
        snap_a_d  = op_a_q;
        snap_b_d  = op_b_q;
        snap_op_d = op_t'(op_code_q);
        busy_d    = 1'b1;
        cnt_d     = '0;
        acc_hi_d  = '0;
        acc_lo_d  = (op_t'(op_code_q) == OP_DIV) ? op_a_q : op_b_q;
        if (((op_t'(op_code_q) == OP_MUL) || (op_t'(op_code_q) == OP_DIV)) && (op_b_q != '0))
          state_d = S_ITER;
        else
          state_d = S_FIN;
      end
      S_ITER: begin
        // MUL: {hi,lo} shifts right, multiplier bits leave lo as product bits enter.
        // DIV: {rem,quo} shifts left, quotient bits enter lo.
        if (snap_op_q == OP_MUL) begin
          {acc_hi_d, acc_lo_d} = {mul_sum, acc_lo_q[DATA_W-1:1]};
        end else begin
          acc_hi_d = div_ge ? div_diff : div_sh[DATA_W-1:0];
          acc_lo_d = {acc_lo_q[DATA_W-2:0], div_ge};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DATA_W - 1)) state_d = S_FIN;
      end
      S_FIN: begin
        res_hi_d = '0;
        ovf_d    = 1'b0;
        dbz_d    = 1'b0;
        case (snap_op_q)
          OP_ADD: {ovf_d, res_lo_d} = add_s;
          OP_SUB: {ovf_d, res_lo_d} = sub_s;
          OP_MUL: begin
            res_lo_d = acc_lo_q;
            res_hi_d = acc_hi_q;
          end
          OP_DIV: begin
            if (snap_b_q == '0) begin
              res_lo_d = '1;
              res_hi_d = snap_a_q;
              dbz_d    = 1'b1;
            end else begin
              res_lo_d = acc_lo_q;
              res_hi_d = acc_hi_q;
            end
          end
          OP_AND:  res_lo_d = snap_a_q & snap_b_q;
          OP_OR:   res_lo_d = snap_a_q | snap_b_q;
          OP_XOR:  res_lo_d = snap_a_q ^ snap_b_q;
          default: res_lo_d = snap_a_q;
        endcase
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (read) begin
      case (address)
        ADDR_W'(0): rd_d = op_a_q;
        ADDR_W'(1): rd_d = op_b_q;
        ADDR_W'(2): rd_d = DATA_W'(op_code_q);
        ADDR_W'(4): rd_d = DATA_W'({ovf_q, dbz_q, done_q, busy_q});
        ADDR_W'(5): rd_d = res_lo_q;
        ADDR_W'(6): rd_d = res_hi_q;
        ADDR_W'(7): rd_d = DATA_W'(irq_en_q);
        default:    rd_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      snap_op_q <= OP_ADD;
      op_a_q    <= '0;
      op_b_q    <= '0;
      op_code_q <= '0;
      irq_en_q  <= 1'b0;
      snap_a_q  <= '0;
      snap_b_q  <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      cnt_q     <= '0;
      res_lo_q  <= '0;
      res_hi_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      ovf_q     <= 1'b0;
      rd_q      <= '0;
    end else begin
      state_q   <= state_d;
      snap_op_q <= snap_op_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      op_code_q <= op_code_d;
      irq_en_q  <= irq_en_d;
      snap_a_q  <= snap_a_d;
      snap_b_q  <= snap_b_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      cnt_q     <= cnt_d;
      res_lo_q  <= res_lo_d;
      res_hi_q  <= res_hi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
      ovf_q     <= ovf_d;
      rd_q      <= rd_d;
    end
  end

  assign read_data = rd_q;
  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign op_code   = op_code_q;
  assign result    = res_lo_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign irq       = done_q & irq_en_q;

endmodule

// File: tb/tb_calc_avalon_engine.sv
// Self-checking bench for calc_avalon_engine: operation table with a result
// scoreboard, plus hand sequences for collisions, interrupts and mid-op reset.
module tb_calc_avalon_engine;
  localparam int DW = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] address = '0;
  logic          read = 1'b0, write = 1'b0;
  logic [DW-1:0] write_data = '0, read_data;
  logic          loc_we = 1'b0;
  logic [1:0]    loc_sel = '0;
  logic [DW-1:0] loc_wdata = '0;
  logic          loc_start = 1'b0;
  logic [DW-1:0] op_a, op_b, result;
  logic [2:0]    op_code;
  logic          busy, done, irq;

  calc_avalon_engine #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .address(address), .read(read), .write(write),
    .write_data(write_data), .read_data(read_data), .loc_we(loc_we),
    .loc_sel(loc_sel), .loc_wdata(loc_wdata), .loc_start(loc_start),
    .op_a(op_a), .op_b(op_b), .op_code(op_code), .result(result),
    .busy(busy), .done(done), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] lo, hi;
    logic          ovf, dbz;
    int unsigned   lat;
  } exp_t;

  typedef struct {
    logic [2:0]    op;
    logic [DW-1:0] a, b, lo, hi;
    logic          ovf, dbz;
    int unsigned   lat;
    int unsigned   mode;  // 0 plain, 1 disturb mid-op, 2 clear on done edge, 3 keypad port
  } vec_t;

  int unsigned n_cmp = 0, n_bad = 0;
  exp_t        sb[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic av_write(input logic [AW-1:0] ad, input logic [DW-1:0] d);
    address = ad; write_data = d; write = 1'b1;
    tick();
    write = 1'b0;
  endtask

  task automatic av_read(input logic [AW-1:0] ad, output logic [DW-1:0] d);
    address = ad; read = 1'b1;
    tick();
    read = 1'b0;
    d = read_data;
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    exp_t e;
    logic [2*DW-1:0] p;
    e = '{lo: '0, hi: '0, ovf: 1'b0, dbz: 1'b0, lat: 2};
    case (op)
      3'd0: begin e.lo = a + b; e.ovf = ({1'b0, a} + {1'b0, b}) > 17'h0FFFF; end
      3'd1: begin e.lo = a - b; e.ovf = (a < b); end
      3'd2: begin p = {16'h0, a} * {16'h0, b}; e.lo = p[DW-1:0]; e.hi = p[2*DW-1:DW]; e.lat = (b != 0) ? 18 : 2; end
      3'd3: begin
        if (b == 0) begin e.lo = 16'hFFFF; e.hi = a; e.dbz = 1'b1; end
        else begin e.lo = a / b; e.hi = a % b; e.lat = 18; end
      end
      3'd4: e.lo = a & b;
      3'd5: e.lo = a | b;
      3'd6: e.lo = a ^ b;
      default: e.lo = a;
    endcase
    return e;
  endfunction

  task automatic run_op(input vec_t v);
    exp_t          e;
    int unsigned   c, busy_n;
    logic [DW-1:0] d;
    if (v.mode == 3) begin
      loc_we = 1'b1;
      loc_sel = 2'd0; loc_wdata = v.a; tick();
      loc_sel = 2'd1; loc_wdata = v.b; tick();
      loc_sel = 2'd2; loc_wdata = DW'(v.op); tick();
      loc_we = 1'b0;
    end else begin
      av_write(0, v.a);
      av_write(1, v.b);
      av_write(2, DW'(v.op));
    end
    sb.push_back('{lo: v.lo, hi: v.hi, ovf: v.ovf, dbz: v.dbz, lat: v.lat});
    if (v.mode == 3) begin
      loc_start = 1'b1; tick(); loc_start = 1'b0;
    end else begin
      av_write(3, 16'h0001);
    end
    chk("done_cleared_on_start", done, 1'b0);
    c = 0; busy_n = 0;
    while (!done && c < 60) begin
      if (v.mode == 1 && c == 3) begin
        write = 1'b1; address = 0; write_data = 16'h0007; loc_start = 1'b1;
      end
      if (v.mode == 2 && c == 1) begin
        write = 1'b1; address = 3; write_data = 16'h0002;
      end
      tick();
      write = 1'b0; loc_start = 1'b0;
      c++;
      if (busy) busy_n++;
    end
    chk("done_seen", done, 1'b1);
    e = sb.pop_front();
    chk("latency", c, e.lat);
    chk("busy_cycles", busy_n, e.lat - 1);
    chk("busy_low_at_done", busy, 1'b0);
    chk("result_lo", result, e.lo);
    av_read(5, d); chk("rd_result_lo", d, e.lo);
    av_read(6, d); chk("rd_result_hi", d, e.hi);
    av_read(4, d); chk("rd_status", d, {12'h0, e.ovf, e.dbz, 1'b1, 1'b0});
    if (v.mode == 1) begin
      av_read(0, d); chk("rd_op_a_new", d, 16'h0007);
      chk("no_queued_start", busy, 1'b0);
    end
  endtask

  vec_t tbl[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] d;
    vec_t          v;
    exp_t          e;

    tbl.push_back('{3'd0, 16'hFFFF, 16'h0002, 16'h0001, 16'h0000, 1'b1, 1'b0, 2, 0});
    tbl.push_back('{3'd1, 16'h0003, 16'h0005, 16'hFFFE, 16'h0000, 1'b1, 1'b0, 2, 0});
    tbl.push_back('{3'd2, 16'd300,  16'd500,  16'h49F0, 16'h0002, 1'b0, 1'b0, 18, 0});
    tbl.push_back('{3'd2, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 1'b0, 18, 0});
    tbl.push_back('{3'd3, 16'd1000, 16'd7,    16'h008E, 16'h0006, 1'b0, 1'b0, 18, 0});
    tbl.push_back('{3'd3, 16'd1234, 16'd0,    16'hFFFF, 16'h04D2, 1'b0, 1'b1, 2, 0});
    tbl.push_back('{3'd4, 16'hF0F0, 16'h3C3C, 16'h3030, 16'h0000, 1'b0, 1'b0, 2, 0});
    tbl.push_back('{3'd5, 16'hF0F0, 16'h3C3C, 16'hFCFC, 16'h0000, 1'b0, 1'b0, 2, 0});
    tbl.push_back('{3'd6, 16'hF0F0, 16'h3C3C, 16'hCCCC, 16'h0000, 1'b0, 1'b0, 2, 0});
    tbl.push_back('{3'd7, 16'h1234, 16'h5678, 16'h1234, 16'h0000, 1'b0, 1'b0, 2, 0});
    tbl.push_back('{3'd0, 16'h0005, 16'h0003, 16'h0008, 16'h0000, 1'b0, 1'b0, 2, 0});
    tbl.push_back('{3'd1, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 1'b0, 1'b0, 2, 0});
    tbl.push_back('{3'd3, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 18, 0});
    tbl.push_back('{3'd3, 16'd7,    16'd1000, 16'h0000, 16'h0007, 1'b0, 1'b0, 18, 0});
    tbl.push_back('{3'd2, 16'd300,  16'd500,  16'h49F0, 16'h0002, 1'b0, 1'b0, 18, 1});
    tbl.push_back('{3'd0, 16'hFFFF, 16'h0002, 16'h0001, 16'h0000, 1'b1, 1'b0, 2, 2});
    tbl.push_back('{3'd0, 16'h0100, 16'h0020, 16'h0120, 16'h0000, 1'b0, 1'b0, 2, 3});

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_read_data", read_data, '0);
    chk("rst_regs", {op_a, op_b, op_code}, '0);
    chk("rst_result", result, '0);
    chk("rst_flags", {busy, done, irq}, 3'b000);
    rst = 1'b1;
    tick();

    foreach (tbl[i]) run_op(tbl[i]);

    for (int i = 0; i < 8; i++) begin
      v.op = 3'($urandom_range(0, 7));
      v.a  = 16'($urandom);
      v.b  = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      if (v.op == 3'd2 && v.b == 0) v.b = 16'h0001;
      e = model(v.op, v.a, v.b);
      v.lo = e.lo; v.hi = e.hi; v.ovf = e.ovf; v.dbz = e.dbz; v.lat = e.lat; v.mode = 0;
      run_op(v);
    end

    // Interrupt enable, then clear via CTRL bit1
    chk("done_before_irq", done, 1'b1);
    av_write(7, 16'h0001);
    chk("irq_set", irq, 1'b1);
    av_read(7, d); chk("rd_irq_en", d, 16'h0001);
    av_write(3, 16'h0002);
    chk("clear_done", done, 1'b0);
    chk("clear_irq", irq, 1'b0);
    av_read(4, d); chk("status_after_clear", d, 16'h0000);
    av_read(9, d); chk("rd_unmapped", d, 16'h0000);
    av_read(3, d); chk("rd_ctrl_zero", d, 16'h0000);

    // Same-register collision: Avalon wins
    write = 1'b1; address = 1; write_data = 16'h0010;
    loc_we = 1'b1; loc_sel = 2'd1; loc_wdata = 16'h0020;
    tick();
    write = 1'b0; loc_we = 1'b0;
    chk("collision_op_b", op_b, 16'h0010);

    // Different registers: both land
    write = 1'b1; address = 0; write_data = 16'h0011;
    loc_we = 1'b1; loc_sel = 2'd2; loc_wdata = 16'h0005;
    tick();
    write = 1'b0; loc_we = 1'b0;
    chk("dual_op_a", op_a, 16'h0011);
    chk("dual_op_code", op_code, 3'd5);

    // Read concurrent with write returns the old value
    read = 1'b1; write = 1'b1; address = 0; write_data = 16'h0099;
    tick();
    read = 1'b0; write = 1'b0;
    chk("read_old_value", read_data, 16'h0011);
    chk("write_landed", op_a, 16'h0099);
    tick();
    chk("read_data_holds", read_data, 16'h0011);

    // Reset mid-DIV
    av_write(0, 16'd1000);
    av_write(1, 16'd7);
    av_write(2, 16'd3);
    av_write(3, 16'h0001);
    repeat (7) tick();
    chk("busy_mid_div", busy, 1'b1);
    #3 rst = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_result", result, '0);
    tick();
    rst = 1'b1;
    tick();
    av_read(4, d); chk("abort_status", d, 16'h0000);
    av_read(6, d); chk("abort_result_hi", d, 16'h0000);
    run_op('{3'd3, 16'd1000, 16'd7, 16'h008E, 16'h0006, 1'b0, 1'b0, 18, 0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
